// File: rtl/alu_sequencer.sv
// Fetch/execute sequencer for a small register-file ALU datapath.
// Fetches 20-bit instructions, decodes ALU/branch/halt ops and counts retired instructions.
module alu_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic [19:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        Zero,
    output logic [3:0]  RA1,
    output logic [3:0]  RA2,
    output logic [3:0]  WA,
    output logic [7:0]  immediate,
    output logic [1:0]  ALUControl,
    output logic        ALUSrc,
    output logic        write_enable,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {IDLE, FETCH, EXECUTE, HALTED} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next;
    logic [19:0] ir_reg, ir_next;
    logic        zflag_reg, zflag_next;
    logic [15:0] retired_reg, retired_next;

    logic [3:0]  op;
    logic        is_alu;

    assign op     = ir_reg[19:16];
    // ALU ops are the 01cc (reg-reg) and 10cc (reg-imm) groups
    assign is_alu = (op[3:2] == 2'b01) || (op[3:2] == 2'b10);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= IDLE;
            pc_reg      <= 8'd0;
            ir_reg      <= 20'd0;
            zflag_reg   <= 1'b0;
            retired_reg <= 16'd0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            zflag_reg   <= zflag_next;
            retired_reg <= retired_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        zflag_next   = zflag_reg;
        retired_next = retired_reg;
        imem_req     = 1'b0;
        write_enable = 1'b0;
        case (state_reg)
            IDLE, HALTED: begin
                if (start) begin
                    state_next   = FETCH;
                    pc_next      = 8'd0;
                    retired_next = 16'd0;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_next    = imem_rdata;
                    state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                write_enable = is_alu;
                state_next   = FETCH;
                if (retired_reg != 16'hFFFF) begin
                    retired_next = retired_reg + 16'd1;
                end
                if (is_alu) begin
                    zflag_next = Zero;
                end
                // BZ tests the flag left by the most recent ALU op, not the live Zero input
                case (op)
                    4'hC:    pc_next = zflag_reg ? ir_reg[7:0] : pc_reg + 8'd1;
                    4'hD:    pc_next = ir_reg[7:0];
                    4'hF:    state_next = HALTED;
                    default: pc_next = pc_reg + 8'd1;
                endcase
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_addr  = pc_reg;
    assign pc         = pc_reg;
    assign WA         = ir_reg[15:12];
    assign RA1        = ir_reg[11:8];
    assign RA2        = ir_reg[7:4];
    assign immediate  = ir_reg[7:0];
    assign ALUSrc     = (op[3:2] == 2'b10);
    assign ALUControl = is_alu ? op[1:0] : 2'b00;
    assign busy       = (state_reg == FETCH) || (state_reg == EXECUTE);
    assign halted     = (state_reg == HALTED);
    assign retired    = retired_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: an instruction-level model predicts every
// EXECUTE cycle's datapath controls, which are popped and compared as the DUT executes.
module tb_alu_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [19:0] imem_rdata;
    logic        imem_valid;
    logic        Zero;
    logic [3:0]  RA1, RA2, WA;
    logic [7:0]  immediate;
    logic [1:0]  ALUControl;
    logic        ALUSrc;
    logic        write_enable;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    logic [19:0] mem  [256];
    logic        zmem [256];

    logic [47:0] exp_q [$];
    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    assign imem_rdata = mem[imem_addr];
    assign Zero       = zmem[imem_addr];

    alu_sequencer dut (
        .CLK(CLK), .RESET(RESET), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .Zero(Zero),
        .RA1(RA1), .RA2(RA2), .WA(WA), .immediate(immediate),
        .ALUControl(ALUControl), .ALUSrc(ALUSrc), .write_enable(write_enable),
        .pc(pc), .busy(busy), .halted(halted), .retired(retired)
    );

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 20'hF0000;
            zmem[i] = 1'b0;
        end
    endtask

    // Instruction-set reference model; assumes zflag starts clear.
    task automatic build_model(output logic [7:0] fpc, output logic [15:0] fret);
        logic [7:0]  p;
        logic        z;
        logic [15:0] r;
        logic [19:0] ir;
        logic [3:0]  op;
        logic        alu;
        logic        done;
        p = 8'd0; z = 1'b0; r = 16'd0; done = 1'b0;
        for (int n = 0; n < 1000 && !done; n++) begin
            ir  = mem[p];
            op  = ir[19:16];
            alu = (op[3:2] == 2'b01) || (op[3:2] == 2'b10);
            exp_q.push_back({p, ir[15:12], ir[11:8], ir[7:4], ir[7:0],
                             (op[3:2] == 2'b10), (alu ? op[1:0] : 2'b00), alu, r});
            if (r != 16'hFFFF) r = r + 16'd1;
            if (alu) begin
                z = zmem[p];
                p = p + 8'd1;
            end else if (op == 4'hC) begin
                p = z ? ir[7:0] : p + 8'd1;
            end else if (op == 4'hD) begin
                p = ir[7:0];
            end else if (op == 4'hF) begin
                done = 1'b1;
            end else begin
                p = p + 8'd1;
            end
        end
        fpc = p;
        fret = r;
    endtask

    task automatic pulse_start();
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
    endtask

    // Pops one expected record per EXECUTE cycle until the program halts.
    task automatic drain(input string name, input logic [7:0] fpc, input logic [15:0] fret,
                         input int pulse_cyc);
        logic [47:0] got, want;
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || !halted) && cyc < 2000) begin
            @(negedge CLK);
            start = (cyc == pulse_cyc);
            cyc++;
            if (busy && !imem_req) begin
                got = {pc, WA, RA1, RA2, immediate, ALUSrc, ALUControl, write_enable, retired};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra_execute got=%h required=none", name, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        miscompares++;
                        $display("FAIL %s execute got=%h required=%h", name, got, want);
                    end else begin
                        $display("%s execute pc=%h we=%b ok", name, pc, write_enable);
                    end
                end
            end else begin
                vectors++;
                if (write_enable !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s we_outside_execute got=%b required=0", name, write_enable);
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (cyc >= 2000) begin
            miscompares++;
            $display("FAIL %s timeout got=%0d_pending required=0", name, exp_q.size());
            exp_q.delete();
        end
        vectors++;
        if ({halted, pc, retired} !== {1'b1, fpc, fret}) begin
            miscompares++;
            $display("FAIL %s final got=%b/%h/%0d required=1/%h/%0d", name, halted, pc, retired, fpc, fret);
        end else begin
            $display("%s final pc=%h retired=%0d ok", name, pc, retired);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; start = 1'b0; imem_valid = 1'b1;
        clear_mem();
        repeat (2) @(negedge CLK);
        vectors++;
        if ({imem_req, write_enable, busy, halted} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctl got=%b required=0000", {imem_req, write_enable, busy, halted});
        end
        vectors++;
        if ({pc, imem_addr, retired} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_count got=%h/%h/%h required=0", pc, imem_addr, retired);
        end
        vectors++;
        if ({WA, RA1, RA2, immediate, ALUControl, ALUSrc} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_fields got=%h required=0", {WA, RA1, RA2, immediate, ALUControl, ALUSrc});
        end
        @(negedge CLK) RESET = 1'b0;
        repeat (2) @(negedge CLK);
        vectors++;
        if ({busy, halted, imem_req} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_hold got=%b required=000", {busy, halted, imem_req});
        end
        $display("test_reset done");
    endtask

    task automatic test_addi();
        logic [7:0] fpc; logic [15:0] fret;
        clear_mem();
        mem[0] = 20'h83005;
        build_model(fpc, fret);
        pulse_start();
        drain("addi", fpc, fret, -1);
    endtask

    task automatic test_halt_prog();
        logic [7:0] fpc; logic [15:0] fret;
        clear_mem();
        mem[0] = 20'h42130;
        mem[1] = 20'hF0000;
        build_model(fpc, fret);
        pulse_start();
        drain("halt_prog", fpc, fret, -1);
        vectors++;
        if ({pc, retired} !== {8'd1, 16'd2}) begin
            miscompares++;
            $display("FAIL halt_prog_const got=%h/%0d required=01/2", pc, retired);
        end
    endtask

    task automatic test_branch();
        logic [7:0] fpc; logic [15:0] fret;
        clear_mem();
        mem[0]    = 20'h41230; zmem[0] = 1'b1;
        mem[1]    = 20'hC0040;
        mem[8'h40] = 20'h41230;
        mem[8'h41] = 20'hC0080;
        build_model(fpc, fret);
        pulse_start();
        drain("branch", fpc, fret, -1);
        vectors++;
        if (pc !== 8'h42) begin
            miscompares++;
            $display("FAIL branch_const got=%h required=42", pc);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] fpc; logic [15:0] fret;
        @(negedge CLK) RESET = 1'b1;
        @(negedge CLK) RESET = 1'b0;
        clear_mem();
        mem[0]     = 20'hC0030;
        mem[1]     = 20'h41230; zmem[1] = 1'b1;
        mem[2]     = 20'hD00FF;
        mem[8'hFF] = 20'h00000;
        build_model(fpc, fret);
        pulse_start();
        drain("wrap", fpc, fret, -1);
        vectors++;
        if ({pc, retired} !== {8'h30, 16'd6}) begin
            miscompares++;
            $display("FAIL wrap_const got=%h/%0d required=30/6", pc, retired);
        end
    endtask

    task automatic test_stall();
        logic [7:0] fpc; logic [15:0] fret;
        clear_mem();
        mem[0] = 20'h83005;
        build_model(fpc, fret);
        imem_valid = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({imem_req, imem_addr, immediate, write_enable} !== {1'b1, 8'd0, 8'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_c%0d got=%b/%h/%h/%b required=1/00/00/0", i,
                         imem_req, imem_addr, immediate, write_enable);
            end else begin
                $display("stall cycle %0d ok", i);
            end
            if (i == 3) imem_valid = 1'b1;
            else @(negedge CLK);
        end
        drain("stall", fpc, fret, -1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] fpc; logic [15:0] fret;
        clear_mem();
        mem[0] = 20'h81101;
        mem[1] = 20'h82202;
        mem[2] = 20'h43120;
        build_model(fpc, fret);
        pulse_start();
        drain("back_to_back", fpc, fret, 2);
    endtask

    task automatic test_reset_mid_exec();
        logic [7:0] fpc; logic [15:0] fret;
        clear_mem();
        mem[0] = 20'h83005;
        pulse_start();
        @(posedge CLK);
        #2;
        vectors++;
        if (write_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_we got=%b required=1", write_enable);
        end
        RESET = 1'b1;
        #1;
        vectors++;
        if ({write_enable, busy, imem_req, pc} !== {3'b000, 8'd0}) begin
            miscompares++;
            $display("FAIL async_reset got=%b/%b/%b/%h required=0/0/0/00", write_enable, busy, imem_req, pc);
        end else begin
            $display("async reset mid execute ok");
        end
        @(negedge CLK) RESET = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            vectors++;
            if ({busy, halted, write_enable} !== 3'b000) begin
                miscompares++;
                $display("FAIL post_reset_idle got=%b required=000", {busy, halted, write_enable});
            end
        end
        exp_q.delete();
        build_model(fpc, fret);
        pulse_start();
        drain("resume", fpc, fret, -1);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_halt_prog();
        test_branch();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
